pipeline_stall_ctrl: RTL and testbench

//  Central stall/flush scheduler for the 5-stage pipeline. Sits beside the ID stage.

---
 rtl/pipeline_stall_ctrl_pkg.sv | 44 ++++
 rtl/pipeline_hazard_detect.sv | 34 +++
 rtl/pipeline_stall_ctrl.sv | 109 ++++++++++
 tb/tb_pipeline_stall_ctrl.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/pipeline_stall_ctrl_pkg.sv
// Shared encodings for the pipeline stall/flush scheduler: FSM states, branch
// opcodes and the per-stage control bundle driven toward the pipeline registers.
package pipeline_stall_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN = 2'b00,
    ST_MD  = 2'b01
  } state_e;

  localparam logic [5:0] OP_Branch_ELSE = 6'b000001;
  localparam logic [5:0] OP_BEQ         = 6'b000100;
  localparam logic [5:0] OP_BNE         = 6'b000101;
  localparam logic [5:0] OP_BLEZ        = 6'b000110;
  localparam logic [5:0] OP_BGTZ        = 6'b000111;

  typedef struct packed {
    logic pc_write;
    logic if_id_write;
    logic if_id_flush;
    logic id_ex_bubble;
    logic id_ex_hold;
    logic ex_mem_bubble;
    logic md_busy;
  } ctrl_t;

  localparam ctrl_t CTRL_RESET = '{pc_write: 1'b0, if_id_write: 1'b0, if_id_flush: 1'b1,
                                   id_ex_bubble: 1'b1, id_ex_hold: 1'b0,
                                   ex_mem_bubble: 1'b1, md_busy: 1'b0};
  localparam ctrl_t CTRL_MD    = '{pc_write: 1'b0, if_id_write: 1'b0, if_id_flush: 1'b0,
                                   id_ex_bubble: 1'b0, id_ex_hold: 1'b1,
                                   ex_mem_bubble: 1'b1, md_busy: 1'b1};
  localparam ctrl_t CTRL_STALL = '{pc_write: 1'b0, if_id_write: 1'b0, if_id_flush: 1'b0,
                                   id_ex_bubble: 1'b1, id_ex_hold: 1'b0,
                                   ex_mem_bubble: 1'b0, md_busy: 1'b0};
  localparam ctrl_t CTRL_RUN   = '{pc_write: 1'b1, if_id_write: 1'b1, if_id_flush: 1'b0,
                                   id_ex_bubble: 1'b0, id_ex_hold: 1'b0,
                                   ex_mem_bubble: 1'b0, md_busy: 1'b0};

  function automatic logic is_branch(input logic [5:0] op);
    return (op == OP_BEQ) || (op == OP_BNE) || (op == OP_BGTZ) ||
           (op == OP_BLEZ) || (op == OP_Branch_ELSE);
  endfunction

endpackage

// File: rtl/pipeline_hazard_detect.sv
// Pure comparator block: load-use (LU), branch-on-ALU-result (BRA) and
// branch-on-load-in-MEM (BRL) hazards for the instruction sitting in ID.
module pipeline_hazard_detect
  import pipeline_stall_ctrl_pkg::*;
(
  input  logic [5:0] i_id_opcode,
  input  logic [4:0] i_if_id_rs,
  input  logic [4:0] i_if_id_rt,
  input  logic [2:0] i_id_ex_mr,
  input  logic       i_id_ex_rw,
  input  logic [4:0] i_id_ex_rt,
  input  logic [4:0] i_id_ex_rd,
  input  logic [2:0] i_ex_mem_mr,
  input  logic [4:0] i_ex_mem_rd,
  output logic       o_lu,
  output logic       o_bra,
  output logic       o_brl
);

  logic w_is_br;

  assign w_is_br = is_branch(i_id_opcode);

  assign o_lu  = (i_id_ex_mr != 3'd0) && (i_id_ex_rt != 5'd0) &&
                 ((i_id_ex_rt == i_if_id_rs) || (i_id_ex_rt == i_if_id_rt));

  // Branches resolve in ID, so even a forwarded ALU result arrives too late.
  assign o_bra = w_is_br && i_id_ex_rw && (i_id_ex_mr == 3'd0) && (i_id_ex_rd != 5'd0) &&
                 ((i_id_ex_rd == i_if_id_rs) || (i_id_ex_rd == i_if_id_rt));

  assign o_brl = w_is_br && (i_ex_mem_mr != 3'd0) && (i_ex_mem_rd != 5'd0) &&
                 ((i_ex_mem_rd == i_if_id_rs) || (i_ex_mem_rd == i_if_id_rt));

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Stall/flush scheduler beside ID: merges hazard stalls and mult/div EX occupancy
// into per-stage controls, flushes IF/ID on taken branches, counts stall cycles.
module pipeline_stall_ctrl
  import pipeline_stall_ctrl_pkg::*;
#(
  parameter int MD_CYCLES = 4,
  parameter int CNT_W     = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [5:0]       i_id_opcode,
  input  logic [4:0]       i_if_id_rs,
  input  logic [4:0]       i_if_id_rt,
  input  logic [2:0]       i_id_ex_mr,
  input  logic             i_id_ex_rw,
  input  logic [4:0]       i_id_ex_rt,
  input  logic [4:0]       i_id_ex_rd,
  input  logic [2:0]       i_ex_mem_mr,
  input  logic [4:0]       i_ex_mem_rd,
  input  logic             i_md_in_ex,
  input  logic             i_branch_taken,
  output logic             o_pc_write,
  output logic             o_if_id_write,
  output logic             o_if_id_flush,
  output logic             o_id_ex_bubble,
  output logic             o_id_ex_hold,
  output logic             o_ex_mem_bubble,
  output logic             o_md_busy,
  output logic [CNT_W-1:0] o_stall_cycles
);

  localparam int              MDW        = (MD_CYCLES > 3) ? $clog2(MD_CYCLES - 2) : 1;
  localparam bit              MD_HAS_ST  = (MD_CYCLES > 2);
  localparam logic [MDW-1:0]  MD_LOAD    = MDW'((MD_CYCLES > 2) ? (MD_CYCLES - 3) : 0);

  state_e           r_state;
  logic [MDW-1:0]   r_md_cnt;
  logic [CNT_W-1:0] r_stall_cycles;
  logic             w_lu;
  logic             w_bra;
  logic             w_brl;
  ctrl_t            w_ctrl;

  pipeline_hazard_detect u_hazard (
    .i_id_opcode (i_id_opcode),
    .i_if_id_rs  (i_if_id_rs),
    .i_if_id_rt  (i_if_id_rt),
    .i_id_ex_mr  (i_id_ex_mr),
    .i_id_ex_rw  (i_id_ex_rw),
    .i_id_ex_rt  (i_id_ex_rt),
    .i_id_ex_rd  (i_id_ex_rd),
    .i_ex_mem_mr (i_ex_mem_mr),
    .i_ex_mem_rd (i_ex_mem_rd),
    .o_lu        (w_lu),
    .o_bra       (w_bra),
    .o_brl       (w_brl)
  );

  // The entry cycle (md_in_ex) already stalls, so ST_MD lasts MD_CYCLES-2 cycles.
  always_comb begin
    w_ctrl = CTRL_RUN;
    if (i_rst) begin
      w_ctrl = CTRL_RESET;
    end else if ((r_state == ST_MD) || i_md_in_ex) begin
      w_ctrl = CTRL_MD;
    end else if (w_lu || w_bra || w_brl) begin
      w_ctrl = CTRL_STALL;
    end else begin
      w_ctrl.if_id_flush = i_branch_taken;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state        <= ST_RUN;
      r_md_cnt       <= '0;
      r_stall_cycles <= '0;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (i_md_in_ex && MD_HAS_ST) begin
            r_state  <= ST_MD;
            r_md_cnt <= MD_LOAD;
          end
        end
        ST_MD: begin
          if (r_md_cnt == '0) r_state <= ST_RUN;
          else                r_md_cnt <= r_md_cnt - 1'b1;
        end
        default: begin
          r_state  <= ST_RUN;
          r_md_cnt <= '0;
        end
      endcase
      if (!w_ctrl.pc_write && (r_stall_cycles != '1))
        r_stall_cycles <= r_stall_cycles + 1'b1;
    end
  end

  assign o_pc_write      = w_ctrl.pc_write;
  assign o_if_id_write   = w_ctrl.if_id_write;
  assign o_if_id_flush   = w_ctrl.if_id_flush;
  assign o_id_ex_bubble  = w_ctrl.id_ex_bubble;
  assign o_id_ex_hold    = w_ctrl.id_ex_hold;
  assign o_ex_mem_bubble = w_ctrl.ex_mem_bubble;
  assign o_md_busy       = w_ctrl.md_busy;
  assign o_stall_cycles  = r_stall_cycles;

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Scoreboard bench for pipeline_stall_ctrl: a reference model predicts each cycle's
// controls and counter, which are queued at drive time and compared at sample time.
module tb_pipeline_stall_ctrl;
  import pipeline_stall_ctrl_pkg::*;

  localparam int MD_CYCLES = 4;
  localparam int CNT_W     = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic [5:0]       id_opcode;
  logic [4:0]       if_id_rs, if_id_rt;
  logic [2:0]       id_ex_mr;
  logic             id_ex_rw;
  logic [4:0]       id_ex_rt, id_ex_rd;
  logic [2:0]       ex_mem_mr;
  logic [4:0]       ex_mem_rd;
  logic             md_in_ex, branch_taken;
  logic             pc_write, if_id_write, if_id_flush, id_ex_bubble, id_ex_hold;
  logic             ex_mem_bubble, md_busy;
  logic [CNT_W-1:0] stall_cycles;

  typedef struct {
    logic [6:0]       ctl;   // {pcw, ifw, flush, bubble, hold, exm_bubble, busy}
    logic [CNT_W-1:0] cnt;
    string            tag;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   m_md_left = 0;
  int   m_cnt = 0;

  always #5 clk = ~clk;

  pipeline_stall_ctrl #(.MD_CYCLES(MD_CYCLES), .CNT_W(CNT_W)) dut (
    .i_clk(clk), .i_rst(rst), .i_id_opcode(id_opcode), .i_if_id_rs(if_id_rs),
    .i_if_id_rt(if_id_rt), .i_id_ex_mr(id_ex_mr), .i_id_ex_rw(id_ex_rw),
    .i_id_ex_rt(id_ex_rt), .i_id_ex_rd(id_ex_rd), .i_ex_mem_mr(ex_mem_mr),
    .i_ex_mem_rd(ex_mem_rd), .i_md_in_ex(md_in_ex), .i_branch_taken(branch_taken),
    .o_pc_write(pc_write), .o_if_id_write(if_id_write), .o_if_id_flush(if_id_flush),
    .o_id_ex_bubble(id_ex_bubble), .o_id_ex_hold(id_ex_hold),
    .o_ex_mem_bubble(ex_mem_bubble), .o_md_busy(md_busy), .o_stall_cycles(stall_cycles)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic bit m_hazard();
    bit br, lu, bra, brl;
    br  = id_opcode inside {OP_BEQ, OP_BNE, OP_BGTZ, OP_BLEZ, OP_Branch_ELSE};
    lu  = (id_ex_mr != 0) && (id_ex_rt != 0) && (id_ex_rt == if_id_rs || id_ex_rt == if_id_rt);
    bra = br && id_ex_rw && (id_ex_mr == 0) && (id_ex_rd != 0) &&
          (id_ex_rd == if_id_rs || id_ex_rd == if_id_rt);
    brl = br && (ex_mem_mr != 0) && (ex_mem_rd != 0) &&
          (ex_mem_rd == if_id_rs || ex_mem_rd == if_id_rt);
    return lu || bra || brl;
  endfunction

  function automatic logic [6:0] m_ctl();
    if (rst)                           return 7'b0011010;
    if (m_md_left > 0 || md_in_ex)     return 7'b0000111;
    if (m_hazard())                    return 7'b0001000;
    return {2'b11, branch_taken, 4'b0000};
  endfunction

  // Called just after a falling edge with inputs already set.
  task automatic step(input string tag, input bit chk);
    exp_t e;
    e.ctl = m_ctl();
    e.cnt = m_cnt[CNT_W-1:0];
    e.tag = tag;
    sb.push_back(e);
    #2;
    e = sb.pop_front();
    if (chk) begin
      check({e.tag, ".pc_write"},      32'(pc_write),      32'(e.ctl[6]));
      check({e.tag, ".if_id_write"},   32'(if_id_write),   32'(e.ctl[5]));
      check({e.tag, ".if_id_flush"},   32'(if_id_flush),   32'(e.ctl[4]));
      check({e.tag, ".id_ex_bubble"},  32'(id_ex_bubble),  32'(e.ctl[3]));
      check({e.tag, ".id_ex_hold"},    32'(id_ex_hold),    32'(e.ctl[2]));
      check({e.tag, ".ex_mem_bubble"}, 32'(ex_mem_bubble), 32'(e.ctl[1]));
      check({e.tag, ".md_busy"},       32'(md_busy),       32'(e.ctl[0]));
      check({e.tag, ".stall_cycles"},  32'(stall_cycles),  32'(e.cnt));
    end
    @(posedge clk);
    if (rst) begin
      m_md_left = 0;
      m_cnt     = 0;
    end else begin
      if (!e.ctl[6] && m_cnt < (1 << CNT_W) - 1) m_cnt++;
      if (m_md_left > 0)  m_md_left--;
      else if (md_in_ex)  m_md_left = MD_CYCLES - 2;
    end
    @(negedge clk);
  endtask

  task automatic clr();
    id_opcode = 6'd0; if_id_rs = 5'd0; if_id_rt = 5'd0;
    id_ex_mr = 3'd0; id_ex_rw = 1'b0; id_ex_rt = 5'd0; id_ex_rd = 5'd0;
    ex_mem_mr = 3'd0; ex_mem_rd = 5'd0; md_in_ex = 1'b0; branch_taken = 1'b0;
  endtask

  task automatic set_lu();
    id_opcode = 6'd0; if_id_rs = 5'd2; if_id_rt = 5'd4;
    id_ex_mr = 3'd2; id_ex_rw = 1'b1; id_ex_rt = 5'd2; id_ex_rd = 5'd2;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    clr();
    @(negedge clk);
    step("rst0", 1);
    step("rst1", 1);
    rst = 1'b0;
    step("idle", 1);

    // lw $2 ; add $3,$2,$4 : one bubble
    set_lu();                                      step("lu", 1);
    clr(); id_ex_rd = 5'd2; if_id_rs = 5'd2; if_id_rt = 5'd4; step("lu_done", 1);
    // LU ignored when the load targets $0
    set_lu(); id_ex_rt = 5'd0;                     step("lu_r0", 1);

    // lw $2 ; beq $2,$0 : LU then BRL, then a taken branch flushes
    clr(); id_opcode = OP_BEQ; if_id_rs = 5'd2; if_id_rt = 5'd0;
    id_ex_mr = 3'd2; id_ex_rt = 5'd2; id_ex_rw = 1'b1; id_ex_rd = 5'd2;
    step("ldbr_lu", 1);
    id_ex_mr = 3'd0; id_ex_rw = 1'b0; id_ex_rt = 5'd0; id_ex_rd = 5'd0;
    ex_mem_mr = 3'd2; ex_mem_rd = 5'd2;            step("ldbr_brl", 1);
    ex_mem_mr = 3'd0; ex_mem_rd = 5'd0; branch_taken = 1'b1; step("ldbr_go", 1);

    // add $5 ; bne $5,$6 : BRA, then $0 destination and non-branch variants
    clr(); id_opcode = OP_BNE; if_id_rs = 5'd5; if_id_rt = 5'd6;
    id_ex_rw = 1'b1; id_ex_rd = 5'd5;              step("bra", 1);
    id_ex_rw = 1'b0; id_ex_rd = 5'd0;              step("bra_done", 1);
    id_ex_rw = 1'b1; id_ex_rd = 5'd0;              step("bra_r0", 1);
    id_opcode = 6'd0; id_ex_rd = 5'd5;             step("bra_nobr", 1);
    id_opcode = OP_Branch_ELSE; if_id_rs = 5'd0; if_id_rt = 5'd5; step("bra_else", 1);

    // mult/div: 3 busy cycles, LU and branch_taken ignored inside the window
    clr(); md_in_ex = 1'b1;                        step("md0", 1);
    md_in_ex = 1'b0; set_lu(); branch_taken = 1'b1; step("md1", 1);
    clr(); id_opcode = OP_BGTZ; if_id_rs = 5'd7; id_ex_rw = 1'b1; id_ex_rd = 5'd7;
    step("md2", 1);
    clr();                                         step("md_exit", 1);

    // taken branch alone vs with LU
    branch_taken = 1'b1;                           step("flush", 1);
    set_lu();                                      step("flush_lu", 1);
    clr();                                         step("run", 1);

    // reset in the second ST_MD cycle aborts the mult/div
    md_in_ex = 1'b1;                               step("mdr0", 1);
    md_in_ex = 1'b0;                               step("mdr1", 1);
    rst = 1'b1;                                    step("mdr_rst", 1);
    rst = 1'b0;                                    step("mdr_after", 1);
    step("mdr_after2", 1);

    // saturation of the stall counter
    set_lu();
    repeat (65540) step("sat", 0);
    step("sat_a", 1);
    step("sat_b", 1);
    check("sat_max", 32'(stall_cycles), 32'h0000_FFFF);
    clr();                                         step("sat_run", 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
